osd_event_packetizer: RTL and testbench

Converts fixed-width trace events from a sampling/buffer stage into Debug Interconnect (DII) event packets on a 16-bit flit stream. It sits directly downstream of the trace FIFO in a trace module (e.g. the STM), consuming `{overflow, data}` entries through a valid/ready handshake. It produces either a normal event packet or an overflow-notification packet on `debug_out`. Each packet consists of a 3-flit header followed by payload flits.

---
 rtl/osd_event_packetizer.sv | 107 ++++++++++
 tb/tb_osd_event_packetizer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_event_packetizer.sv
// Turns {overflow, data} trace entries into DII event packets: a 3-flit header
// (dest, src, type) followed by the payload words, LSB word first.
package osd_dii_pkg;
  typedef struct packed {
    logic        valid;
    logic        last;
    logic [15:0] data;
  } dii_flit;
endpackage

module osd_event_packetizer
  import osd_dii_pkg::*;
#(
  parameter int WIDTH = 112
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       id,
  input  logic [15:0]      event_dest,
  input  logic [WIDTH-1:0] trace_data,
  input  logic             trace_overflow,
  input  logic             trace_valid,
  output logic             trace_ready,
  output dii_flit          debug_out,
  input  logic             debug_out_ready
);

  localparam int N  = (WIDTH + 15) / 16;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = N * 16;

  typedef enum logic [2:0] {IDLE, DEST, SRC, TYPE, PAYLOAD} state_t;

  // Handshakes: a transfer happens on any rising edge where valid and ready are
  // both high; valid never depends on ready, and a flit holds while stalled.
  state_t        state, state_next;
  logic [PW-1:0] data_q;
  logic          ovf_q;
  logic [15:0]   dest_q;
  logic [CW-1:0] cnt, cnt_next;
  logic          accept, flit_done, last_word;

  assign trace_ready = (state == IDLE) && !rst;
  assign accept      = trace_valid && trace_ready;
  assign flit_done   = (state != IDLE) && debug_out_ready;
  assign last_word   = ovf_q || (cnt == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      data_q <= '0;
      ovf_q  <= 1'b0;
      dest_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) begin
        data_q <= PW'(trace_data);
        ovf_q  <= trace_overflow;
        dest_q <= event_dest;
      end
    end
  end

  // Flit fields are decoded from registered state only, never from trace_*.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    debug_out  = '0;
    case (state)
      IDLE: begin
        if (accept) state_next = DEST;
      end
      DEST: begin
        debug_out.valid = 1'b1;
        debug_out.data  = dest_q;
        if (flit_done) state_next = SRC;
      end
      SRC: begin
        debug_out.valid = 1'b1;
        debug_out.data  = {6'b0, id};
        if (flit_done) state_next = TYPE;
      end
      TYPE: begin
        debug_out.valid = 1'b1;
        debug_out.data  = ovf_q ? 16'h9400 : 16'h8000;
        if (flit_done) state_next = PAYLOAD;
      end
      PAYLOAD: begin
        debug_out.valid = 1'b1;
        debug_out.last  = last_word;
        debug_out.data  = ovf_q ? data_q[15:0] : data_q[{cnt, 4'b0} +: 16];
        if (flit_done) begin
          if (last_word) begin
            state_next = IDLE;
            cnt_next   = '0;
          end else begin
            cnt_next = cnt + CW'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_osd_event_packetizer.sv
// Bench for osd_event_packetizer: a 112-bit and a 40-bit instance checked
// flit by flit against a packet-level model, plus literal packet checks.
module tb_osd_event_packetizer;
  import osd_dii_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [9:0]   id = 10'h005;
  logic [15:0]  event_dest = '0;
  logic         debug_out_ready = 1'b0;
  logic [111:0] trace_data = '0;
  logic         trace_overflow = 1'b0, trace_valid = 1'b0, trace_ready;
  dii_flit      debug_out;
  logic [39:0]  trace_data_w40 = '0;
  logic         trace_overflow_w40 = 1'b0, trace_valid_w40 = 1'b0, trace_ready_w40;
  dii_flit      debug_out_w40;

  osd_event_packetizer #(.WIDTH(112)) dut (
    .clk(clk), .rst(rst), .id(id), .event_dest(event_dest),
    .trace_data(trace_data), .trace_overflow(trace_overflow),
    .trace_valid(trace_valid), .trace_ready(trace_ready),
    .debug_out(debug_out), .debug_out_ready(debug_out_ready));

  osd_event_packetizer #(.WIDTH(40)) dut_w40 (
    .clk(clk), .rst(rst), .id(id), .event_dest(event_dest),
    .trace_data(trace_data_w40), .trace_overflow(trace_overflow_w40),
    .trace_valid(trace_valid_w40), .trace_ready(trace_ready_w40),
    .debug_out(debug_out_w40), .debug_out_ready(debug_out_ready));

  // scoreboard: {last, data} of every flit still owed by each instance
  logic [16:0] exp_q0[$], exp_q1[$];
  logic [16:0] obs_q0[$], obs_q1[$];
  int asserts = 0, failures = 0;
  logic rand_bp = 1'b0;
  logic held0 = 1'b0, held1 = 1'b0;
  dii_flit prev0, prev1;

  logic [16:0] lit_evt [10] = '{17'h0_0000, 17'h0_0005, 17'h0_8000, 17'h0_4455, 17'h0_2233,
                                17'h0_0011, 17'h0_CDEF, 17'h0_89AB, 17'h0_4567, 17'h1_0123};
  logic [16:0] lit_ovf [4]  = '{17'h0_0000, 17'h0_0005, 17'h0_9400, 17'h1_0007};
  logic [16:0] lit_w40 [6]  = '{17'h0_0000, 17'h0_0005, 17'h0_8000, 17'h0_5678, 17'h0_1234,
                                17'h1_00FF};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void fail_now(input string name);
    asserts++;
    failures++;
    $display("FAIL %s at %0t", name, $time);
  endfunction

  // model: the whole packet a given entry must turn into
  task automatic model(input int inst, input logic [111:0] d, input logic ovf,
                       input logic [15:0] dest);
    int w, n;
    logic [127:0] v;
    logic [16:0] pkt[$];
    w = (inst != 0) ? 40 : 112;
    n = (w + 15) / 16;
    v = {16'h0, d} & ((128'd1 << w) - 128'd1);
    pkt.push_back({1'b0, dest});
    pkt.push_back({1'b0, 6'b0, id});
    pkt.push_back({1'b0, ovf ? 16'h9400 : 16'h8000});
    if (ovf) pkt.push_back({1'b1, v[15:0]});
    else for (int k = 0; k < n; k++) pkt.push_back({k == n - 1, 16'(v >> (16 * k))});
    foreach (pkt[i]) begin
      if (inst != 0) exp_q1.push_back(pkt[i]);
      else exp_q0.push_back(pkt[i]);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_bp) debug_out_ready = ($urandom_range(0, 1) != 0);
  endtask

  task automatic send(input int inst, input logic [111:0] d, input logic ovf,
                      input logic [15:0] dest);
    int n;
    logic rdy;
    n = 0;
    event_dest = dest;
    if (inst != 0) begin
      trace_data_w40 = d[39:0]; trace_overflow_w40 = ovf; trace_valid_w40 = 1'b1;
    end else begin
      trace_data = d; trace_overflow = ovf; trace_valid = 1'b1;
    end
    forever begin
      @(negedge clk);
      rdy = (inst != 0) ? trace_ready_w40 : trace_ready;
      tick();
      if (rdy) break;
      n++;
      if (n > 500) begin
        fail_now("accept_timeout");
        return;
      end
    end
    model(inst, d, ovf, dest);
    event_dest = 16'($urandom);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      fail_now("drain_timeout");
      exp_q0.delete();
      exp_q1.delete();
    end
    tick();
    tick();
  endtask

  // compare process: every flit handshake and every stall cycle
  always @(negedge clk) begin
    if (rst) begin
      held0 = 1'b0;
      held1 = 1'b0;
    end else begin
      if (held0) check("stall_hold", {14'b0, debug_out}, {14'b0, prev0});
      if (debug_out.valid && debug_out_ready) begin
        if (exp_q0.size() == 0) fail_now("unexpected_flit");
        else check("flit", {15'b0, debug_out.last, debug_out.data}, {15'b0, exp_q0.pop_front()});
        obs_q0.push_back({debug_out.last, debug_out.data});
        held0 = 1'b0;
      end else begin
        held0 = debug_out.valid;
        prev0 = debug_out;
      end
      if (held1) check("stall_hold_w40", {14'b0, debug_out_w40}, {14'b0, prev1});
      if (debug_out_w40.valid && debug_out_ready) begin
        if (exp_q1.size() == 0) fail_now("unexpected_flit_w40");
        else check("flit_w40", {15'b0, debug_out_w40.last, debug_out_w40.data},
                   {15'b0, exp_q1.pop_front()});
        obs_q1.push_back({debug_out_w40.last, debug_out_w40.data});
        held1 = 1'b0;
      end else begin
        held1 = debug_out_w40.valid;
        prev1 = debug_out_w40;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    #3;
    check("rst_trace_ready", trace_ready, 0);
    check("rst_debug_out", {14'b0, debug_out}, 0);
    check("rst_debug_out_w40", {14'b0, debug_out_w40}, 0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("ready_after_rst", trace_ready, 1);
    debug_out_ready = 1'b1;

    // normal event, ready=1, with trace_ready timing and DEST latency
    obs_q0.delete();
    send(0, 112'h0123_4567_89AB_CDEF_0011_2233_4455, 1'b0, 16'h0000);
    trace_valid = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      check("ready_timing", trace_ready, (i == 11) ? 1 : 0);
      if (i == 1) check("dest_latency", {debug_out.valid, debug_out.data}, {1'b1, 16'h0000});
    end
    tick();
    check("evt_len", obs_q0.size(), 10);
    for (int i = 0; i < 10; i++)
      if (i < obs_q0.size()) check("evt_literal", obs_q0[i], lit_evt[i]);

    // overflow entry; junk above bit 15 must be dropped
    obs_q0.delete();
    send(0, {96'hDEAD_BEEF_0000_FFFF_1234_5678, 16'h0007}, 1'b1, 16'h0000);
    trace_valid = 1'b0;
    drain();
    check("ovf_len", obs_q0.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < obs_q0.size()) check("ovf_literal", obs_q0[i], lit_ovf[i]);

    // padding on the 40-bit instance
    obs_q1.delete();
    send(1, 112'hFF_1234_5678, 1'b0, 16'h0000);
    trace_valid_w40 = 1'b0;
    drain();
    check("w40_len", obs_q1.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < obs_q1.size()) check("w40_literal", obs_q1[i], lit_w40[i]);

    // reset during a stalled SRC flit
    debug_out_ready = 1'b0;
    send(0, 112'h1111_2222_3333_4444_5555_6666_7777, 1'b0, 16'h1234);
    trace_valid = 1'b0;
    debug_out_ready = 1'b1;
    tick();
    debug_out_ready = 1'b0;
    @(negedge clk);
    check("stall_on_src", debug_out.data, 16'h0005);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", debug_out.valid, 0);
    check("rst_async_ready", trace_ready, 0);
    exp_q0.delete();
    @(negedge clk);
    tick();
    rst = 1'b0;
    #1;
    check("ready_after_mid_rst", trace_ready, 1);
    debug_out_ready = 1'b1;
    obs_q0.delete();
    send(0, 112'hAAAA_BBBB_CCCC_DDDD_EEEE_FFFF_0001, 1'b0, 16'h0042);
    trace_valid = 1'b0;
    drain();
    check("fresh_len", obs_q0.size(), 10);
    if (obs_q0.size() > 0) check("fresh_dest", obs_q0[0], 17'h0_0042);

    // back-to-back valid: normal, overflow, normal
    obs_q0.delete();
    send(0, 112'h1, 1'b0, 16'h0A0A);
    send(0, 112'h2, 1'b1, 16'h0B0B);
    send(0, 112'h3, 1'b0, 16'h0C0C);
    trace_valid = 1'b0;
    drain();
    check("b2b_len", obs_q0.size(), 24);
    if (obs_q0.size() == 24) begin
      check("b2b_type0", obs_q0[2], 17'h0_8000);
      check("b2b_type1", obs_q0[12], 17'h0_9400);
      check("b2b_type2", obs_q0[16], 17'h0_8000);
    end

    // random backpressure, 100 back-to-back events, then a few on the 40-bit instance
    rand_bp = 1'b1;
    for (int i = 0; i < 100; i++)
      send(0, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) == 0,
           16'($urandom));
    trace_valid = 1'b0;
    for (int i = 0; i < 10; i++)
      send(1, {80'h0, $urandom, $urandom}, $urandom_range(0, 3) == 0, 16'($urandom));
    trace_valid_w40 = 1'b0;
    drain();
    rand_bp = 1'b0;
    check("final_idle", trace_ready, 1);
    check("final_idle_w40", trace_ready_w40, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
